mrv1_mt_ifetch: RTL and testbench

Parametrised multi-thread instruction fetch unit for the MRV1 multithreaded core, placed between the thread control logic and decode. It holds a per-thread PC table, picks a fetchable thread round-robin, and issues registered, stable requests to IMEM. It tracks up to `MAX_OUTST_P` in-order responses and buffers instructions in a tagged fetch queue. Per-thread redirects are handled by epoch tags: only the redirected thread's stale fetches are discarded, with no global flush.

---
 rtl/mrv1_mt_ifetch.sv | 253 +++++++++++++++++++++++++
 tb/tb_mrv1_mt_ifetch.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mrv1_mt_ifetch.sv
// MRV1 multithreaded fetch: per-thread PC table, round-robin grant, in-order IMEM tags, epoch-filtered queue.
// Optional MRV1_IFETCH_BYPASS_EN: a current-epoch response into an empty queue goes straight to decode.
module mrv1_mt_ifetch #(
    parameter int          NUM_THREADS_P = 8,
    parameter int          IFQ_DEPTH_P   = 4,
    parameter int          MAX_OUTST_P   = 2,
    parameter logic [31:0] RESET_PC_P    = 32'h0000_0000,
    localparam int         tid_width_lp  = $clog2(NUM_THREADS_P)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    fetch_en_i,
    output logic                    imem_req_vld_o,
    input  logic                    imem_req_rdy_i,
    output logic [31:0]             imem_req_addr_o,
    input  logic                    imem_resp_vld_i,
    input  logic [31:0]             imem_resp_data_i,
    output logic                    insn_vld_o,
    input  logic                    insn_rdy_i,
    output logic [31:0]             insn_data_o,
    output logic [31:0]             insn_pc_o,
    output logic [tid_width_lp-1:0] insn_tid_o,
    input  logic                    exec_redir_vld_i,
    input  logic [tid_width_lp-1:0] exec_redir_tid_i,
    input  logic [31:0]             exec_redir_pc_i,
    input  logic                    dec_redir_vld_i,
    input  logic [tid_width_lp-1:0] dec_redir_tid_i,
    input  logic [31:0]             dec_redir_pc_i,
    input  logic                    th_spawn_vld_i,
    input  logic [tid_width_lp-1:0] th_spawn_tid_i,
    input  logic [31:0]             th_spawn_pc_i,
    input  logic                    th_kill_vld_i,
    input  logic [tid_width_lp-1:0] th_kill_tid_i,
    input  logic                    th_stall_vld_i,
    input  logic [tid_width_lp-1:0] th_stall_tid_i,
    input  logic                    th_stall_set_i
);
    localparam int q_ptr_w_lp = (IFQ_DEPTH_P > 1) ? $clog2(IFQ_DEPTH_P) : 1;
    localparam int q_cnt_w_lp = $clog2(IFQ_DEPTH_P + 1);
    localparam int t_ptr_w_lp = (MAX_OUTST_P > 1) ? $clog2(MAX_OUTST_P) : 1;
    localparam int o_cnt_w_lp = $clog2(MAX_OUTST_P + 1);

    typedef logic [tid_width_lp-1:0] tid_t;

    function automatic tid_t rr_idx(input tid_t base, input int off);
        return tid_t'((int'(base) + off) % NUM_THREADS_P);
    endfunction

    function automatic logic [q_ptr_w_lp-1:0] q_inc(input logic [q_ptr_w_lp-1:0] p);
        return (int'(p) == IFQ_DEPTH_P - 1) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [t_ptr_w_lp-1:0] t_inc(input logic [t_ptr_w_lp-1:0] p);
        return (int'(p) == MAX_OUTST_P - 1) ? '0 : p + 1'b1;
    endfunction

    logic [31:0]              r_pc [NUM_THREADS_P];
    logic [NUM_THREADS_P-1:0] r_active, r_stalled, r_inflight, r_epoch;
    logic [31:0]              w_pc_nxt [NUM_THREADS_P];
    logic [NUM_THREADS_P-1:0] w_active_nxt, w_stalled_nxt, w_inflight_nxt, w_epoch_nxt;
    logic [NUM_THREADS_P-1:0] w_elig;

    logic                     r_req_vld, r_req_epoch;
    logic [31:0]              r_req_addr;
    tid_t                     r_req_tid, r_last_tid;
    logic [o_cnt_w_lp-1:0]    r_outst;

    logic [31:0]              r_tag_pc [MAX_OUTST_P];
    tid_t                     r_tag_tid [MAX_OUTST_P];
    logic [MAX_OUTST_P-1:0]   r_tag_epoch;
    logic [t_ptr_w_lp-1:0]    r_tag_wr, r_tag_rd;

    logic [31:0]              r_ifq_data [IFQ_DEPTH_P];
    logic [31:0]              r_ifq_pc [IFQ_DEPTH_P];
    tid_t                     r_ifq_tid [IFQ_DEPTH_P];
    logic [IFQ_DEPTH_P-1:0]   r_ifq_epoch;
    logic [q_ptr_w_lp-1:0]    r_ifq_wr, r_ifq_rd;
    logic [q_cnt_w_lp-1:0]    r_ifq_count;

    logic        w_any_elig, w_grant, w_req_accept, w_resp_keep, w_bypass;
    logic        w_head_stale, w_head_vld, w_enq, w_deq, w_tag_epoch;
    tid_t        w_grant_tid, w_tag_tid, w_head_tid;
    logic [31:0] w_tag_pc;

    assign w_elig = r_active & ~r_stalled & ~r_inflight;

    // Scan from farthest to nearest so the tid right after the last grant wins.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the block infers a latch.
        w_any_elig  = 1'b0;
        w_grant_tid = '0;
        for (int i = NUM_THREADS_P; i >= 1; i--) begin
            if (w_elig[rr_idx(r_last_tid, i)]) begin
                w_any_elig  = 1'b1;
                w_grant_tid = rr_idx(r_last_tid, i);
            end
        end
    end

    // The credit term reserves a queue slot for every outstanding fetch.
    assign w_grant = fetch_en_i & w_any_elig & (~r_req_vld | imem_req_rdy_i)
                   & (int'(r_outst) < MAX_OUTST_P)
                   & (int'(r_ifq_count) + int'(r_outst) < IFQ_DEPTH_P);
    assign w_req_accept = r_req_vld & imem_req_rdy_i;

    assign w_tag_pc    = r_tag_pc[r_tag_rd];
    assign w_tag_tid   = r_tag_tid[r_tag_rd];
    assign w_tag_epoch = r_tag_epoch[r_tag_rd];
    assign w_resp_keep = imem_resp_vld_i & (w_tag_epoch == r_epoch[w_tag_tid]) & r_active[w_tag_tid];

    always_comb begin
        for (int t = 0; t < NUM_THREADS_P; t++) begin
            w_pc_nxt[t]       = r_pc[t];
            w_active_nxt[t]   = r_active[t];
            w_stalled_nxt[t]  = r_stalled[t];
            w_epoch_nxt[t]    = r_epoch[t];
            w_inflight_nxt[t] = r_inflight[t];
            if (th_stall_vld_i && th_stall_tid_i == tid_t'(t)) w_stalled_nxt[t] = th_stall_set_i;
            if (imem_resp_vld_i && w_tag_tid == tid_t'(t))     w_inflight_nxt[t] = 1'b0;
            if (w_grant && w_grant_tid == tid_t'(t))           w_inflight_nxt[t] = 1'b1;
            if (exec_redir_vld_i && exec_redir_tid_i == tid_t'(t)) begin
                w_pc_nxt[t]    = exec_redir_pc_i;
                w_epoch_nxt[t] = ~r_epoch[t];
            end else if (dec_redir_vld_i && dec_redir_tid_i == tid_t'(t)) begin
                w_pc_nxt[t]    = dec_redir_pc_i;
                w_epoch_nxt[t] = ~r_epoch[t];
            end else if (th_spawn_vld_i && th_spawn_tid_i == tid_t'(t)) begin
                w_pc_nxt[t]      = th_spawn_pc_i;
                w_active_nxt[t]  = 1'b1;
                w_stalled_nxt[t] = 1'b0;
                w_epoch_nxt[t]   = ~r_epoch[t];
            end else if (th_kill_vld_i && th_kill_tid_i == tid_t'(t)) begin
                w_active_nxt[t] = 1'b0;
                w_epoch_nxt[t]  = ~r_epoch[t];
            end else if (w_grant && w_grant_tid == tid_t'(t)) begin
                w_pc_nxt[t] = r_pc[t] + 32'd4;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int t = 0; t < NUM_THREADS_P; t++) r_pc[t] <= (t == 0) ? RESET_PC_P : 32'd0;
            r_active   <= {{(NUM_THREADS_P-1){1'b0}}, 1'b1};
            r_stalled  <= '0;
            r_inflight <= '0;
            r_epoch    <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values of the others.
            for (int t = 0; t < NUM_THREADS_P; t++) r_pc[t] <= w_pc_nxt[t];
            r_active   <= w_active_nxt;
            r_stalled  <= w_stalled_nxt;
            r_inflight <= w_inflight_nxt;
            r_epoch    <= w_epoch_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_req_vld   <= 1'b0;
            r_req_addr  <= '0;
            r_req_tid   <= '0;
            r_req_epoch <= 1'b0;
            r_last_tid  <= tid_t'(NUM_THREADS_P - 1);
            r_outst     <= '0;
        end else begin
            if (w_grant) begin
                r_req_vld   <= 1'b1;
                r_req_addr  <= {r_pc[w_grant_tid][31:2], 2'b00};
                r_req_tid   <= w_grant_tid;
                r_req_epoch <= r_epoch[w_grant_tid];
                r_last_tid  <= w_grant_tid;
            end else if (w_req_accept) begin
                r_req_vld <= 1'b0;
            end
            case ({w_grant, imem_resp_vld_i})
                2'b10:   r_outst <= r_outst + 1'b1;
                2'b01:   r_outst <= r_outst - 1'b1;
                default: r_outst <= r_outst;
            endcase
        end
    end

    // NOTE: tag and queue payloads are reset as well, so every output is a defined 0 out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MAX_OUTST_P; i++) begin
                r_tag_pc[i]  <= '0;
                r_tag_tid[i] <= '0;
            end
            r_tag_epoch <= '0;
            r_tag_wr    <= '0;
            r_tag_rd    <= '0;
        end else begin
            if (w_req_accept) begin
                r_tag_pc[r_tag_wr]    <= r_req_addr;
                r_tag_tid[r_tag_wr]   <= r_req_tid;
                r_tag_epoch[r_tag_wr] <= r_req_epoch;
                r_tag_wr              <= t_inc(r_tag_wr);
            end
            if (imem_resp_vld_i) r_tag_rd <= t_inc(r_tag_rd);
        end
    end

`ifdef MRV1_IFETCH_BYPASS_EN
    assign w_bypass = w_resp_keep & (r_ifq_count == '0) & insn_rdy_i;
`else
    assign w_bypass = 1'b0;
`endif

    // A head from an older epoch of its thread is dropped without being shown to decode.
    assign w_head_tid   = r_ifq_tid[r_ifq_rd];
    assign w_head_stale = (r_ifq_count != '0) & (r_ifq_epoch[r_ifq_rd] != r_epoch[w_head_tid]);
    assign w_head_vld   = (r_ifq_count != '0) & ~w_head_stale;
    assign w_enq        = w_resp_keep & ~w_bypass;
    assign w_deq        = (w_head_vld & insn_rdy_i) | w_head_stale;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < IFQ_DEPTH_P; i++) begin
                r_ifq_data[i] <= '0;
                r_ifq_pc[i]   <= '0;
                r_ifq_tid[i]  <= '0;
            end
            r_ifq_epoch <= '0;
            r_ifq_wr    <= '0;
            r_ifq_rd    <= '0;
            r_ifq_count <= '0;
        end else begin
            if (w_enq) begin
                r_ifq_data[r_ifq_wr]  <= imem_resp_data_i;
                r_ifq_pc[r_ifq_wr]    <= w_tag_pc;
                r_ifq_tid[r_ifq_wr]   <= w_tag_tid;
                r_ifq_epoch[r_ifq_wr] <= w_tag_epoch;
                r_ifq_wr              <= q_inc(r_ifq_wr);
            end
            if (w_deq) r_ifq_rd <= q_inc(r_ifq_rd);
            case ({w_enq, w_deq})
                2'b10:   r_ifq_count <= r_ifq_count + 1'b1;
                2'b01:   r_ifq_count <= r_ifq_count - 1'b1;
                default: r_ifq_count <= r_ifq_count;
            endcase
        end
    end

    assign imem_req_vld_o  = r_req_vld;
    assign imem_req_addr_o = r_req_addr;
    assign insn_vld_o      = w_head_vld | w_bypass;
    assign insn_data_o     = w_bypass ? imem_resp_data_i : r_ifq_data[r_ifq_rd];
    assign insn_pc_o       = w_bypass ? w_tag_pc : r_ifq_pc[r_ifq_rd];
    assign insn_tid_o      = w_bypass ? w_tag_tid : w_head_tid;

endmodule

// File: tb/tb_mrv1_mt_ifetch.sv
// Directed bench for mrv1_mt_ifetch: an IMEM with 1-cycle response, request/decode logs, per-step checks.
module tb_mrv1_mt_ifetch;
    localparam logic [31:0] RST_PC = 32'h100;

    logic        clk, rst_n, fetch_en;
    logic        req_vld, req_rdy, resp_vld, insn_vld, insn_rdy;
    logic [31:0] req_addr, resp_data, insn_data, insn_pc;
    logic [2:0]  insn_tid;
    logic        ex_vld, dc_vld, sp_vld, kl_vld, st_vld, st_set;
    logic [2:0]  ex_tid, dc_tid, sp_tid, kl_tid, st_tid;
    logic [31:0] ex_pc, dc_pc, sp_pc;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic [2:0]  tid;
    } insn_rec_t;

    insn_rec_t   insn_log[$];
    logic [31:0] req_log[$];
    int          n_checks = 0;
    int          n_errors = 0;

    mrv1_mt_ifetch #(.NUM_THREADS_P(8), .IFQ_DEPTH_P(4), .MAX_OUTST_P(2), .RESET_PC_P(RST_PC)) dut (
        .clk_i(clk), .rst_ni(rst_n), .fetch_en_i(fetch_en),
        .imem_req_vld_o(req_vld), .imem_req_rdy_i(req_rdy), .imem_req_addr_o(req_addr),
        .imem_resp_vld_i(resp_vld), .imem_resp_data_i(resp_data),
        .insn_vld_o(insn_vld), .insn_rdy_i(insn_rdy), .insn_data_o(insn_data),
        .insn_pc_o(insn_pc), .insn_tid_o(insn_tid),
        .exec_redir_vld_i(ex_vld), .exec_redir_tid_i(ex_tid), .exec_redir_pc_i(ex_pc),
        .dec_redir_vld_i(dc_vld), .dec_redir_tid_i(dc_tid), .dec_redir_pc_i(dc_pc),
        .th_spawn_vld_i(sp_vld), .th_spawn_tid_i(sp_tid), .th_spawn_pc_i(sp_pc),
        .th_kill_vld_i(kl_vld), .th_kill_tid_i(kl_tid),
        .th_stall_vld_i(st_vld), .th_stall_tid_i(st_tid), .th_stall_set_i(st_set)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    function automatic insn_rec_t ilog(input int i);
        if (i < insn_log.size()) return insn_log[i];
        return '1;
    endfunction

    function automatic logic [31:0] rlog(input int i);
        if (i < req_log.size()) return req_log[i];
        return '1;
    endfunction

    function automatic logic req_seen(input logic [31:0] a);
        foreach (req_log[i]) if (req_log[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        req_log.delete();
        insn_log.delete();
    endtask

    // IMEM: a request accepted at an edge answers during the following cycle.
    initial begin
        logic        pend;
        logic [31:0] pend_data;
        pend = 1'b0; pend_data = '0; resp_vld = 1'b0; resp_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 1'b0; resp_vld = 1'b0; resp_data = '0;
            end else begin
                resp_vld  = pend;
                resp_data = pend_data;
                pend      = req_vld & req_rdy;
                pend_data = imem_word(req_addr);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (req_vld && req_rdy) req_log.push_back(req_addr);
                if (insn_vld && insn_rdy) insn_log.push_back('{pc: insn_pc, data: insn_data, tid: insn_tid});
            end
        end
    end

    initial begin
        logic [31:0] rr_pc  [6];
        logic [2:0]  rr_tid [6];
        logic        found;
        int          n_t0, n_stale;
        logic [31:0] t0_pc [2];
        logic [31:0] t1_first;

        fetch_en = 1'b1; req_rdy = 1'b1; insn_rdy = 1'b1;
        ex_vld = 0; dc_vld = 0; sp_vld = 0; kl_vld = 0; st_vld = 0; st_set = 0;
        ex_tid = 0; dc_tid = 0; sp_tid = 0; kl_tid = 0; st_tid = 0;
        ex_pc = 0; dc_pc = 0; sp_pc = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // Reset values and first-request latency.
        step(3);
        check("rst_req_vld", req_vld, 0);
        check("rst_req_addr", req_addr, 0);
        check("rst_insn_vld", insn_vld, 0);
        check("rst_insn_data", insn_data, 0);
        check("rst_insn_pc", insn_pc, 0);
        check("rst_insn_tid", insn_tid, 0);
        rst_n = 1'b1;
        check("req_vld_cycle_n", req_vld, 0);
        step(1);
        check("req_vld_cycle_n1", req_vld, 1);
        check("req_addr_first", req_addr, RST_PC);
        step(10);
        fetch_en = 1'b0;
        step(6);
        check("t0_req_count_ge3", 32'(req_log.size() >= 3), 1);
        for (int i = 0; i < 3; i++) begin
            check("t0_req_addr", rlog(i), RST_PC + 32'(4 * i));
            check("t0_insn_pc", ilog(i).pc, RST_PC + 32'(4 * i));
            check("t0_insn_data", ilog(i).data, imem_word(RST_PC + 32'(4 * i)));
            check("t0_insn_tid", ilog(i).tid, 0);
        end
        check("idle_insn_vld", insn_vld, 0);
        check("idle_req_vld", req_vld, 0);

        // Round-robin over three threads; last grant was tid 0, so tid 1 leads.
        clear_logs();
        ex_vld = 1; ex_tid = 0; ex_pc = 32'h1000;
        sp_vld = 1; sp_tid = 1; sp_pc = 32'h2000;
        step(1);
        ex_vld = 0; sp_tid = 2; sp_pc = 32'h3000;
        step(1);
        sp_vld = 0;
        fetch_en = 1'b1;
        step(12);
        fetch_en = 1'b0;
        step(8);
        rr_pc  = '{32'h2000, 32'h3000, 32'h1000, 32'h2004, 32'h3004, 32'h1004};
        rr_tid = '{3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd0};
        for (int i = 0; i < 6; i++) begin
            check("rr_req_addr", rlog(i), rr_pc[i]);
            check("rr_insn_pc", ilog(i).pc, rr_pc[i]);
            check("rr_insn_tid", ilog(i).tid, rr_tid[i]);
        end

        // Backpressure with only tid 0 running: credit stops issue at 4.
        clear_logs();
        st_vld = 1; st_tid = 1; st_set = 1;
        ex_vld = 1; ex_tid = 0; ex_pc = 32'h7000;
        step(1);
        ex_vld = 0; st_tid = 2;
        step(1);
        st_vld = 0;
        insn_rdy = 1'b0;
        fetch_en = 1'b1;
        step(20);
        check("bp_req_count", req_log.size(), 4);
        for (int i = 0; i < 4; i++) check("bp_req_addr", rlog(i), 32'h7000 + 32'(4 * i));
        check("bp_no_handshake", insn_log.size(), 0);
        check("bp_head_vld", insn_vld, 1);
        check("bp_head_pc", insn_pc, 32'h7000);
        check("bp_head_data", insn_data, imem_word(32'h7000));
        check("bp_req_idle", req_vld, 0);
        step(3);
        check("bp_head_stable", insn_pc, 32'h7000);
        fetch_en = 1'b0;
        insn_rdy = 1'b1;
        step(6);
        check("bp_drain_count", insn_log.size(), 4);
        for (int i = 0; i < 4; i++) check("bp_drain_pc", ilog(i).pc, 32'h7000 + 32'(4 * i));
        check("bp_empty_vld", insn_vld, 0);

        // Redirect tid 1 with one entry queued and one fetch in flight.
        clear_logs();
        st_vld = 1; st_tid = 1; st_set = 0;
        ex_vld = 1; ex_tid = 0; ex_pc = 32'h8000;
        dc_vld = 1; dc_tid = 1; dc_pc = 32'h9000;
        step(1);
        st_vld = 0; ex_vld = 0; dc_vld = 0;
        insn_rdy = 1'b0;
        fetch_en = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            step(1);
            found = req_seen(32'h9004);
        end
        check("stale_trigger_seen", found, 1);
        ex_vld = 1; ex_tid = 1; ex_pc = 32'h4000;
        step(1);
        ex_vld = 0;
        step(6);
        insn_rdy = 1'b1;
        step(15);
        fetch_en = 1'b0;
        step(8);
        n_t0 = 0; n_stale = 0; t0_pc = '{'1, '1}; t1_first = '1;
        foreach (insn_log[i]) begin
            if (insn_log[i].pc == 32'h9000 || insn_log[i].pc == 32'h9004) n_stale++;
            if (insn_log[i].tid == 3'd0 && n_t0 < 2) begin
                t0_pc[n_t0] = insn_log[i].pc;
                n_t0++;
            end
            if (insn_log[i].tid == 3'd1 && t1_first == '1) t1_first = insn_log[i].pc;
        end
        check("stale_first_out", ilog(0).pc, 32'h8000);
        check("stale_t0_first", t0_pc[0], 32'h8000);
        check("stale_t0_second", t0_pc[1], 32'h8004);
        check("stale_dropped", n_stale, 0);
        check("redir_t1_first_pc", t1_first, 32'h4000);

        // Exec and dec redirect on tid 2 in one cycle: exec wins.
        st_vld = 1; st_tid = 0; st_set = 1;
        ex_vld = 1; ex_tid = 2; ex_pc = 32'h5000;
        dc_vld = 1; dc_tid = 2; dc_pc = 32'h6000;
        step(1);
        ex_vld = 0; dc_vld = 0; st_tid = 1;
        step(1);
        st_tid = 2; st_set = 0;
        step(1);
        st_vld = 0;
        clear_logs();
        fetch_en = 1'b1;
        step(4);
        fetch_en = 1'b0;
        step(6);
        check("conflict_req_addr", rlog(0), 32'h5000);
        check("conflict_insn_pc", ilog(0).pc, 32'h5000);
        check("conflict_insn_tid", ilog(0).tid, 2);
        check("conflict_insn_data", ilog(0).data, imem_word(32'h5000));

        // Held request stays stable; async reset drops it mid-cycle.
        ex_vld = 1; ex_tid = 2; ex_pc = 32'hA000;
        step(1);
        ex_vld = 0;
        req_rdy = 1'b0;
        fetch_en = 1'b1;
        step(1);
        for (int i = 0; i < 5; i++) begin
            check("hold_vld", req_vld, 1);
            check("hold_addr", req_addr, 32'hA000);
            step(1);
        end
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_req_vld", req_vld, 0);
        check("async_rst_req_addr", req_addr, 0);
        check("async_rst_insn_vld", insn_vld, 0);
        step(2);
        req_rdy = 1'b1;
        rst_n = 1'b1;
        step(1);
        check("post_rst_req_vld", req_vld, 1);
        check("post_rst_req_addr", req_addr, RST_PC);
        step(4);
        fetch_en = 1'b0;
        step(6);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
